// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC array result path.
// Holds the drain FSM states, the lane-index width helper and the default accumulator width.
package mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int D_W_ACC_DEF = 8;

  // Width of a lane index; never narrower than one bit, so a single-lane build still has a field.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_drain_if.sv
// Bundle between the MAC array / writeback side and the result drain.
// The slave side is the drain itself; the master side drives tiles in and consumes beats.
interface mac_drain_if
  import mac_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int D_W_ACC = D_W_ACC_DEF
) ();

  localparam int LANE_W = lane_w(N_LANES);

  logic [N_LANES*D_W_ACC-1:0] acc_in;
  logic                       acc_valid;
  logic                       out_ready;
  logic                       clr_err;
  logic [D_W_ACC-1:0]         out_data;
  logic [LANE_W-1:0]          out_lane;
  logic                       out_valid;
  logic                       out_last;
  logic                       busy;
  logic                       overrun;

  modport slave (
    input  acc_in, acc_valid, out_ready, clr_err,
    output out_data, out_lane, out_valid, out_last, busy, overrun
  );

  modport master (
    output acc_in, acc_valid, out_ready, clr_err,
    input  out_data, out_lane, out_valid, out_last, busy, overrun
  );

endinterface

// File: rtl/mac_drain.sv
// Captures a finished tile of MAC lane results into a shadow bank in one cycle and
// streams it out one lane per beat, letting the array start the next tile immediately.
module mac_drain
  import mac_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int D_W_ACC = D_W_ACC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mac_drain_if.slave  bus
);

  localparam int LANE_W = lane_w(N_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [D_W_ACC-1:0]  r_bank [N_LANES];
  logic [D_W_ACC-1:0]  r_data;
  logic [D_W_ACC-1:0]  w_data_nxt;
  logic [LANE_W-1:0]   r_lane;
  logic [LANE_W-1:0]   w_lane_nxt;
  logic [LANE_W-1:0]   w_lane_inc;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                r_busy;
  logic                r_ovr;
  logic                w_cap;
  logic                w_ovr_evt;
  logic                w_xfer;

  assign w_xfer     = r_valid && bus.out_ready;
  assign w_lane_inc = r_lane + LANE_W'(1);

  // The presented lane doubles as the drain index; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_lane_nxt  = r_lane;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_cap       = 1'b0;
    w_ovr_evt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.acc_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = DRAIN;
          w_valid_nxt = 1'b1;
          w_data_nxt  = bus.acc_in[D_W_ACC-1:0];
          w_lane_nxt  = '0;
          w_last_nxt  = (LAST_LANE == '0);
        end
      end
      DRAIN: begin
        if (w_xfer && r_last) begin
          if (bus.acc_valid) begin
            w_cap      = 1'b1;
            w_data_nxt = bus.acc_in[D_W_ACC-1:0];
            w_lane_nxt = '0;
            w_last_nxt = (LAST_LANE == '0);
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end else begin
          if (w_xfer) begin
            w_lane_nxt = w_lane_inc;
            w_data_nxt = r_bank[w_lane_inc];
            w_last_nxt = (w_lane_inc == LAST_LANE);
          end
          // A tile arriving while the bank is still in use is dropped.
          w_ovr_evt = bus.acc_valid;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_lane  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_lane  <= w_lane_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= (w_state_nxt == DRAIN);
      if (w_ovr_evt) begin
        r_ovr <= 1'b1;
      end else if (bus.clr_err) begin
        r_ovr <= 1'b0;
      end
    end
  end

  // Shadow bank contents are meaningless until a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int i = 0; i < N_LANES; i++) begin
        r_bank[i] <= bus.acc_in[i*D_W_ACC +: D_W_ACC];
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_lane  = r_lane;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_mac_drain.sv
// Self-checking bench for mac_drain: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the pending beats.
module tb_mac_drain;

  localparam int N_LANES = 4;
  localparam int D_W_ACC = 8;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  logic [D_W_ACC-1:0] modelQueue [$];
  bit                 modelOverrun;

  mac_drain_if #(.N_LANES(N_LANES), .D_W_ACC(D_W_ACC)) drainIf ();

  mac_drain #(.N_LANES(N_LANES), .D_W_ACC(D_W_ACC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (drainIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a tile is just N_LANES beats waiting in order; the drain is busy while any remain.
  task automatic modelEdge(input logic [31:0] acc, input bit av, input bit rdy, input bit clr);
    bit ovrEvent;
    bit finalBeat;
    ovrEvent = 1'b0;
    if (modelQueue.size() == 0) begin
      if (av) for (int i = 0; i < N_LANES; i++) modelQueue.push_back(acc[i*D_W_ACC +: D_W_ACC]);
    end else begin
      finalBeat = rdy && (modelQueue.size() == 1);
      if (rdy) void'(modelQueue.pop_front());
      if (av) begin
        if (finalBeat) for (int i = 0; i < N_LANES; i++) modelQueue.push_back(acc[i*D_W_ACC +: D_W_ACC]);
        else ovrEvent = 1'b1;
      end
    end
    if (ovrEvent) modelOverrun = 1'b1;
    else if (clr) modelOverrun = 1'b0;
  endtask

  task automatic compareAll();
    bit active;
    active = (modelQueue.size() != 0);
    checkOutput("out_valid", 32'(drainIf.out_valid), 32'(active));
    checkOutput("busy", 32'(drainIf.busy), 32'(active));
    checkOutput("overrun", 32'(drainIf.overrun), 32'(modelOverrun));
    checkOutput("out_last", 32'(drainIf.out_last), 32'(active && modelQueue.size() == 1));
    if (active) begin
      checkOutput("out_data", 32'(drainIf.out_data), 32'(modelQueue[0]));
      checkOutput("out_lane", 32'(drainIf.out_lane), 32'(N_LANES - modelQueue.size()));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] acc, input bit av, input bit rdy, input bit clr);
    @(negedge clk);
    drainIf.acc_in    = acc;
    drainIf.acc_valid = av;
    drainIf.out_ready = rdy;
    drainIf.clr_err   = clr;
    @(posedge clk);
    modelEdge(acc, av, rdy, clr);
    #1;
    compareAll();
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, " out_data"},  32'(drainIf.out_data),  32'd0);
    checkOutput({phase, " out_lane"},  32'(drainIf.out_lane),  32'd0);
    checkOutput({phase, " out_valid"}, 32'(drainIf.out_valid), 32'd0);
    checkOutput({phase, " out_last"},  32'(drainIf.out_last),  32'd0);
    checkOutput({phase, " busy"},      32'(drainIf.busy),      32'd0);
    checkOutput({phase, " overrun"},   32'(drainIf.overrun),   32'd0);
  endtask

  localparam logic [31:0] TILE_A = 32'h04030201;
  localparam logic [31:0] TILE_B = 32'hFF807F00;

  initial begin
    testCount         = 0;
    failCount         = 0;
    modelOverrun      = 1'b0;
    rst               = 1'b1;
    drainIf.acc_in    = '0;
    drainIf.acc_valid = 1'b0;
    drainIf.out_ready = 1'b0;
    drainIf.clr_err   = 1'b0;
    #1;
    checkResetOutputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Single tile with an always-ready sink.
    applyStimulus(TILE_A, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N_LANES + 1; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Backpressure while lane1 is shown.
    applyStimulus(TILE_A, 1'b1, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Back-to-back tiles: second capture coincides with the lane3 transfer.
    applyStimulus(TILE_A, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus(TILE_B, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N_LANES + 1; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0);

    // Overrun, clear, then clear coinciding with a new overrun.
    applyStimulus(TILE_A, 1'b1, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus(TILE_B, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    applyStimulus(TILE_A, 1'b1, 1'b1, 1'b0);
    applyStimulus(TILE_B, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-drain with overrun still set.
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    #2;
    rst               = 1'b1;
    drainIf.acc_valid = 1'b0;
    drainIf.clr_err   = 1'b0;
    #1;
    checkResetOutputs("midrst");
    modelQueue.delete();
    modelOverrun = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'(i * 7 + 3), 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
